multicycle_main_fsm: RTL and testbench

- Control FSM for the multicycle RV32I core. It replaces the single-cycle main decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback states, and sends Moore-style control signals to the shared datapath.
- Adds wait-state memory handshake, a memory timeout watchdog, bne, jalr, lui and auipc.
- Sits between the instruction register opcode field and the datapath muxes, register-file write enable and memory interface.

---
 rtl/mc_ctrl_pkg.sv | 67 ++++++
 rtl/mem_watchdog.sv | 34 +++
 rtl/multicycle_main_fsm.sv | 186 ++++++++++++++++++
 tb/tb_multicycle_main_fsm.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - state, opcode and datapath select encodings for the multicycle RV32I control FSM
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RESET,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXER,
        S_EXEI,
        S_ALUWB,
        S_BRANCH,
        S_JALRADR,
        S_JAL,
        S_LUI,
        S_AUIPC,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] ALUA_PC    = 2'b00;
    localparam logic [1:0] ALUA_OLDPC = 2'b01;
    localparam logic [1:0] ALUA_RS1   = 2'b10;
    localparam logic [1:0] ALUA_ZERO  = 2'b11;

    localparam logic [1:0] ALUB_RS2  = 2'b00;
    localparam logic [1:0] ALUB_IMM  = 2'b01;
    localparam logic [1:0] ALUB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    function automatic logic [2:0] imm_decode(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_JALR, OP_IMM: imm_decode = IMM_I;
            OP_STORE:                 imm_decode = IMM_S;
            OP_BRANCH:                imm_decode = IMM_B;
            OP_JAL:                   imm_decode = IMM_J;
            OP_LUI, OP_AUIPC:         imm_decode = IMM_U;
            default:                  imm_decode = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/mem_watchdog.sv
// rtl/mem_watchdog.sv - counts unanswered memory wait cycles and flags a timeout; MEM_TIMEOUT=0 disables it
module mem_watchdog #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic mem_ready,
    output logic timeout
);

    generate
        if (MEM_TIMEOUT > 0) begin : g_wd
            localparam int CW = $clog2(MEM_TIMEOUT + 1);
            logic [CW-1:0] cnt;

            // The cycle that would be wait number MEM_TIMEOUT fires instead of counting on.
            assign timeout = active && !mem_ready && (cnt == CW'(MEM_TIMEOUT - 1));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt <= '0;
                end else if (!active || mem_ready || timeout) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end else begin : g_off
            assign timeout = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/multicycle_main_fsm.sv
// rtl/multicycle_main_fsm.sv - multicycle RV32I control FSM with memory wait/timeout; ILLEGAL_TRAP_EN enables the illegal-opcode trap state
module multicycle_main_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int IMM_SRC_W   = 3,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 adr_src,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 reg_write,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic [1:0]           result_src,
    output logic [IMM_SRC_W-1:0] imm_src,
    output logic                 bus_error,
    output logic                 illegal_instr
);

    state_t state, state_next;
    logic   pc_update, branch, wd_active, timeout;
    logic   unused_funct3;

    assign unused_funct3 = ^funct3[2:1];

    assign wd_active = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);

    mem_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wd (
        .clk       (clk),
        .rst_n     (rst_n),
        .active    (wd_active),
        .mem_ready (mem_ready),
        .timeout   (timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RESET;
        end else begin
            state <= state_next;
        end
    end

    assign pc_write  = pc_update | (branch & (zero ^ funct3[0]));
    assign bus_error = timeout;

    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_update  = 1'b0;
        branch     = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = ALUA_PC;
        alu_src_b  = ALUB_RS2;
        alu_op     = ALUOP_ADD;
        result_src = RES_ALUOUT;
        imm_src    = IMM_SRC_W'(imm_decode(op));
        case (state)
            S_RESET: begin
                imm_src    = '0;
                state_next = S_FETCH;
            end
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = ALUB_FOUR;
                result_src = RES_ALU;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_update  = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a = ALUA_OLDPC;
                alu_src_b = ALUB_IMM;
                case (op)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_R:              state_next = S_EXER;
                    OP_IMM:            state_next = S_EXEI;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_JAL:            state_next = S_JAL;
                    OP_JALR:           state_next = S_JALRADR;
                    OP_LUI:            state_next = S_LUI;
                    OP_AUIPC:          state_next = S_AUIPC;
`ifdef ILLEGAL_TRAP_EN
                    default:           state_next = S_TRAP;
`else
                    default:           state_next = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = ALUA_RS1;
                alu_src_b  = ALUB_IMM;
                state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready)    state_next = S_MEMWB;
                else if (timeout) state_next = S_FETCH;
            end
            S_MEMWB: begin
                result_src = RES_RDATA;
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (mem_ready || timeout) state_next = S_FETCH;
            end
            S_EXER: begin
                alu_src_a  = ALUA_RS1;
                alu_op     = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_EXEI: begin
                alu_src_a  = ALUA_RS1;
                alu_src_b  = ALUB_IMM;
                alu_op     = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = ALUA_RS1;
                alu_op     = ALUOP_SUB;
                branch     = 1'b1;
                state_next = S_FETCH;
            end
            S_JALRADR: begin
                alu_src_a  = ALUA_RS1;
                alu_src_b  = ALUB_IMM;
                state_next = S_JAL;
            end
            // Jump target already sits in ALUOut; the ALU meanwhile forms the link value oldPC+4.
            S_JAL: begin
                alu_src_a  = ALUA_OLDPC;
                alu_src_b  = ALUB_FOUR;
                pc_update  = 1'b1;
                state_next = S_ALUWB;
            end
            S_LUI: begin
                alu_src_a  = ALUA_ZERO;
                alu_src_b  = ALUB_IMM;
                state_next = S_ALUWB;
            end
            S_AUIPC: begin
                alu_src_a  = ALUA_OLDPC;
                alu_src_b  = ALUB_IMM;
                state_next = S_ALUWB;
            end
            S_TRAP: begin
                imm_src    = '0;
                state_next = S_TRAP;
            end
            default: begin
                imm_src    = '0;
                state_next = S_RESET;
            end
        endcase
    end

`ifdef ILLEGAL_TRAP_EN
    assign illegal_instr = (state == S_TRAP);
`else
    assign illegal_instr = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// tb/tb_multicycle_main_fsm.sv - scoreboard bench for multicycle_main_fsm; illegal-op expectations follow ILLEGAL_TRAP_EN
module tb_multicycle_main_fsm;

    typedef struct packed {
        logic       mem_req;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] aop;
        logic [1:0] res;
        logic [2:0] imm;
        logic       bus_error;
        logic       illegal;
    } out_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = 7'b0;
    logic [2:0] funct3 = 3'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, adr_src, mem_write, ir_write, pc_write, reg_write;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
    logic [2:0] imm_src;
    logic       bus_error, illegal_instr;

    out_t  exp_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_fail = 0;

    always #5 clk = ~clk;

    multicycle_main_fsm #(.IMM_SRC_W(3), .MEM_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .adr_src(adr_src),
        .mem_write(mem_write), .ir_write(ir_write), .pc_write(pc_write),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .result_src(result_src), .imm_src(imm_src),
        .bus_error(bus_error), .illegal_instr(illegal_instr)
    );

    function automatic out_t v(input logic mr, input logic as, input logic mw, input logic ir,
                               input logic pw, input logic rw, input logic [1:0] a, input logic [1:0] b,
                               input logic [1:0] aop, input logic [1:0] res, input logic [2:0] imm,
                               input logic be, input logic ill);
        out_t o;
        o = '{mr, as, mw, ir, pw, rw, a, b, aop, res, imm, be, ill};
        return o;
    endfunction

    function automatic out_t zeros();
        return v(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,0);
    endfunction
    function automatic out_t f_rdy(input logic [2:0] imm);
        return v(1,0,0,1,1,0,2'b00,2'b10,2'b00,2'b10,imm,0,0);
    endfunction
    function automatic out_t dec(input logic [2:0] imm);
        return v(0,0,0,0,0,0,2'b01,2'b01,2'b00,2'b00,imm,0,0);
    endfunction
    function automatic out_t memadr(input logic [2:0] imm);
        return v(0,0,0,0,0,0,2'b10,2'b01,2'b00,2'b00,imm,0,0);
    endfunction
    function automatic out_t memwr(input logic [2:0] imm, input logic be);
        return v(1,1,1,0,0,0,2'b00,2'b00,2'b00,2'b00,imm,be,0);
    endfunction
    function automatic out_t aluwb(input logic [2:0] imm);
        return v(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,imm,0,0);
    endfunction
    function automatic out_t br(input logic pw);
        return v(0,0,0,0,pw,0,2'b10,2'b00,2'b01,2'b00,3'b010,0,0);
    endfunction

    task automatic step(input logic r, input logic [6:0] o, input logic [2:0] f3, input logic z,
                        input logic rdy, input out_t e, input string nm);
        @(posedge clk);
        #1;
        rst_n = r; op = o; funct3 = f3; zero = z; mem_ready = rdy;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            out_t  e, act;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            act = '{mem_req, adr_src, mem_write, ir_write, pc_write, reg_write, alu_src_a,
                    alu_src_b, alu_op, result_src, imm_src, bus_error, illegal_instr};
            n_checks++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL %s: got %b want %b (mr,as,mw,ir,pw,rw,a,b,aop,res,imm,be,ill)", nm, act, e);
            end
        end
    end

    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] BR   = 7'b1100011;
    localparam logic [6:0] JALR = 7'b1100111;
    localparam logic [6:0] LUI  = 7'b0110111;
    localparam logic [6:0] RTY  = 7'b0110011;
    localparam logic [6:0] BAD  = 7'b1111111;

    initial begin
        step(0, LW, 3'b000, 0, 1, zeros(), "reset_hold");
        step(1, LW, 3'b000, 0, 1, zeros(), "reset_release");
        step(1, LW, 3'b000, 0, 1, f_rdy(3'b000), "lw_fetch");
        step(1, LW, 3'b000, 0, 0, dec(3'b000), "lw_decode");
        step(1, LW, 3'b000, 0, 0, memadr(3'b000), "lw_memadr");
        for (int i = 0; i < 4; i++)
            step(1, LW, 3'b000, 0, (i == 3), v(1,1,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,0), "lw_memread");
        step(1, LW, 3'b000, 0, 1, v(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b01,3'b000,0,0), "lw_memwb");

        for (int k = 0; k < 4; k++) begin
            logic [2:0] f3;
            logic       z;
            f3 = (k < 2) ? 3'b001 : 3'b000;
            z  = k[0];
            step(1, BR, f3, z, 1, f_rdy(3'b010), "br_fetch");
            step(1, BR, f3, z, 0, dec(3'b010), "br_decode");
            step(1, BR, f3, z, 0, br(z ^ f3[0]), "br_branch");
        end

        step(1, JALR, 3'b000, 0, 1, f_rdy(3'b000), "jalr_fetch");
        step(1, JALR, 3'b000, 0, 0, dec(3'b000), "jalr_decode");
        step(1, JALR, 3'b000, 0, 0, memadr(3'b000), "jalr_adr");
        step(1, JALR, 3'b000, 0, 0, v(0,0,0,0,1,0,2'b01,2'b10,2'b00,2'b00,3'b000,0,0), "jalr_jal");
        step(1, JALR, 3'b000, 0, 0, aluwb(3'b000), "jalr_aluwb");

        step(1, LUI, 3'b000, 0, 1, f_rdy(3'b100), "lui_fetch");
        step(1, LUI, 3'b000, 0, 0, dec(3'b100), "lui_decode");
        step(1, LUI, 3'b000, 0, 0, v(0,0,0,0,0,0,2'b11,2'b01,2'b00,2'b00,3'b100,0,0), "lui_exe");
        step(1, LUI, 3'b000, 0, 0, aluwb(3'b100), "lui_aluwb");

        step(1, RTY, 3'b000, 0, 1, f_rdy(3'b000), "r_fetch");
        step(1, RTY, 3'b000, 0, 0, dec(3'b000), "r_decode");
        step(1, RTY, 3'b000, 0, 0, v(0,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0), "r_exe");
        step(1, RTY, 3'b000, 0, 0, aluwb(3'b000), "r_aluwb");

        step(1, SW, 3'b000, 0, 1, f_rdy(3'b001), "swto_fetch");
        step(1, SW, 3'b000, 0, 0, dec(3'b001), "swto_decode");
        step(1, SW, 3'b000, 0, 0, memadr(3'b001), "swto_memadr");
        for (int i = 1; i <= 16; i++)
            step(1, SW, 3'b000, 0, 0, memwr(3'b001, i == 16), "swto_wait");
        step(1, SW, 3'b000, 0, 1, f_rdy(3'b001), "swto_refetch");

        step(1, SW, 3'b000, 0, 0, dec(3'b001), "swrdy_decode");
        step(1, SW, 3'b000, 0, 0, memadr(3'b001), "swrdy_memadr");
        for (int i = 1; i <= 16; i++)
            step(1, SW, 3'b000, 0, (i == 16), memwr(3'b001, 1'b0), "swrdy_wait");
        step(1, SW, 3'b000, 0, 1, f_rdy(3'b001), "swrdy_fetch");

        step(1, SW, 3'b000, 0, 0, dec(3'b001), "swrst_decode");
        step(1, SW, 3'b000, 0, 0, memadr(3'b001), "swrst_memadr");
        step(1, SW, 3'b000, 0, 0, memwr(3'b001, 1'b0), "swrst_memwrite");
        step(0, SW, 3'b000, 0, 1, zeros(), "swrst_abort");
        step(1, SW, 3'b000, 0, 1, zeros(), "swrst_release");

        step(1, BAD, 3'b000, 0, 1, f_rdy(3'b000), "bad_fetch");
        step(1, BAD, 3'b000, 0, 1, dec(3'b000), "bad_decode");
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 3; i++)
            step(1, BAD, 3'b000, 0, 1, v(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,1), "bad_trap");
        step(0, LW, 3'b000, 0, 1, zeros(), "bad_trap_reset");
        step(1, LW, 3'b000, 0, 1, zeros(), "bad_trap_release");
        step(1, LW, 3'b000, 0, 1, f_rdy(3'b000), "bad_trap_fetch");
`else
        step(1, BAD, 3'b000, 0, 1, f_rdy(3'b000), "bad_nop_fetch");
        step(1, LW, 3'b000, 0, 0, dec(3'b000), "bad_nop_decode");
`endif

        @(posedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
